// File: rtl/exfifo_pkt_buf.sv
// exfifo_pkt_buf: packet-committing show-ahead FIFO; optional stall watchdog under EXFIFO_PKT_TIMEOUT_EN
module exfifo_pkt_buf #(
  parameter int PKT_WORDS   = 16,
  parameter int DEPTH_PKTS  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_rst,
  input  logic        h_wr,
  input  logic [31:0] h_wdata,
  output logic        h_wrfull,
  output logic [31:0] exfifo_if_d,
  input  logic        exfifo_if_rd,
  output logic        exfifo_if_rdempty,
  output logic        ovf,
  output logic [7:0]  drop_cnt
);
  localparam int DEPTH = PKT_WORDS * DEPTH_PKTS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PKT_WORDS);
  localparam int PW = AW + 1;

  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic ovf_q, ovf_d, we, re, last, rst, expire;

  assign rst = reset | sw_rst;
  assign h_wrfull = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign exfifo_if_rdempty = rd_ptr_q == commit_ptr_q;
  assign exfifo_if_d = exfifo_if_rdempty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign we = h_wr & ~h_wrfull;
  assign re = exfifo_if_rd & ~exfifo_if_rdempty;
  assign last = we && wcnt_q == CW'(PKT_WORDS - 1);
  assign ovf = ovf_q;

`ifdef EXFIFO_PKT_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic [7:0] drop_q, drop_d;
  // expiry fires on the edge where the idle count would reach TIMEOUT_CYC; an accepted write suppresses it
  assign expire = !we && wcnt_q != '0 && tmo_q == 16'(TIMEOUT_CYC - 1);
  assign drop_cnt = drop_q;
  // idle counter runs only while a partial packet waits; drop counter saturates
  always_comb begin
    tmo_d = (we || wcnt_q == '0 || expire) ? '0 : tmo_q + 16'd1;
    drop_d = (expire && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  end
  // watchdog state
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      drop_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      drop_q <= drop_d;
    end
  end
`else
  assign expire = 1'b0;
  assign drop_cnt = '0;
`endif

  // next-state pointers: a timeout rewinds the write pointer to the last committed packet
  always_comb begin
    wr_ptr_d = expire ? commit_ptr_q : we ? wr_ptr_q + PW'(1) : wr_ptr_q;
    commit_ptr_d = last ? wr_ptr_q + PW'(1) : commit_ptr_q;
    rd_ptr_d = re ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wcnt_d = expire ? '0 : we ? wcnt_q + CW'(1) : wcnt_q;
    ovf_d = ovf_q | (h_wr & h_wrfull);
  end

  // control state; either reset source flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q <= '0;
      wcnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wcnt_q <= wcnt_d;
      ovf_q <= ovf_d;
    end
  end

  // storage; contents need no reset since reads are gated by the pointers
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= h_wdata;
  end
endmodule

// File: tb/tb_exfifo_pkt_buf.sv
// tb_exfifo_pkt_buf: directed self-checking bench for exfifo_pkt_buf
module tb_exfifo_pkt_buf;
  logic clk = 1'b0, reset = 1'b0, sw_rst = 1'b0, h_wr = 1'b0, exfifo_if_rd = 1'b0;
  logic [31:0] h_wdata = '0;
  logic h_wrfull, exfifo_if_rdempty, ovf;
  logic [31:0] exfifo_if_d;
  logic [7:0] drop_cnt;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  exfifo_pkt_buf #(.PKT_WORDS(16), .DEPTH_PKTS(4), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset(reset), .sw_rst(sw_rst), .h_wr(h_wr), .h_wdata(h_wdata),
    .h_wrfull(h_wrfull), .exfifo_if_d(exfifo_if_d), .exfifo_if_rd(exfifo_if_rd),
    .exfifo_if_rdempty(exfifo_if_rdempty), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    h_wr = 1'b1;
    h_wdata = d;
    tick();
    h_wr = 1'b0;
  endtask

  task automatic rd();
    exfifo_if_rd = 1'b1;
    tick();
    exfifo_if_rd = 1'b0;
  endtask

  task automatic drain_pkt(input string tag, input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_d"}, exfifo_if_d, base + 32'(i));
      rd();
    end
    chk({tag, "_empty"}, {31'd0, exfifo_if_rdempty}, 32'd1);
  endtask

  initial begin
    int widx, ridx;
    logic started;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_empty", {31'd0, exfifo_if_rdempty}, 32'd1);
    chk("rst_full", {31'd0, h_wrfull}, 32'd0);
    chk("rst_d", exfifo_if_d, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

    rd();
    chk("rd_empty_ignored", {31'd0, exfifo_if_rdempty}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      wr(32'h1000 + 32'(i));
      chk("one_empty", {31'd0, exfifo_if_rdempty}, (i == 15) ? 32'd0 : 32'd1);
    end
    drain_pkt("one", 32'h1000);
    chk("one_d0", exfifo_if_d, 32'd0);

    for (int i = 0; i < 64; i++) begin
      wr(32'h2000 + 32'(i));
      if (i >= 62) chk("fill_full", {31'd0, h_wrfull}, (i == 63) ? 32'd1 : 32'd0);
    end
    chk("fill_ovf_pre", {31'd0, ovf}, 32'd0);
    wr(32'hdead);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_full", {31'd0, h_wrfull}, 32'd1);
    chk("ovf_head", exfifo_if_d, 32'h2000);
    rd();
    chk("pop_full", {31'd0, h_wrfull}, 32'd0);
    chk("pop_head", exfifo_if_d, 32'h2001);
    wr(32'haaaa);
    chk("refill_full", {31'd0, h_wrfull}, 32'd1);
    for (int i = 1; i < 64; i++) begin
      chk("fill_d", exfifo_if_d, 32'h2000 + 32'(i));
      rd();
    end
    chk("partial_hidden", {31'd0, exfifo_if_rdempty}, 32'd1);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    chk("swrst_ovf", {31'd0, ovf}, 32'd0);
    chk("swrst_empty", {31'd0, exfifo_if_rdempty}, 32'd1);

    widx = 0;
    ridx = 0;
    started = 1'b0;
    for (int c = 0; c < 200; c++) begin
      h_wr = widx < 160;
      h_wdata = 32'h3000 + 32'(widx);
      if (!exfifo_if_rdempty) started = 1'b1;
      if (started && ridx < 160) begin
        chk("str_empty", {31'd0, exfifo_if_rdempty}, 32'd0);
        chk("str_d", exfifo_if_d, 32'h3000 + 32'(ridx));
        exfifo_if_rd = 1'b1;
        ridx++;
      end else exfifo_if_rd = 1'b0;
      tick();
      if (widx < 160) widx++;
    end
    h_wr = 1'b0;
    exfifo_if_rd = 1'b0;
    chk("str_count", 32'(ridx), 32'd160);
    chk("str_ovf", {31'd0, ovf}, 32'd0);
    chk("str_end_empty", {31'd0, exfifo_if_rdempty}, 32'd1);

    for (int i = 0; i < 5; i++) wr(32'h4000 + 32'(i));
    repeat (100) tick();
    chk("tmo_empty", {31'd0, exfifo_if_rdempty}, 32'd1);
`ifdef EXFIFO_PKT_TIMEOUT_EN
    chk("tmo_drop", {24'd0, drop_cnt}, 32'd1);
    for (int i = 0; i < 16; i++) wr(32'h5000 + 32'(i));
    drain_pkt("tmo_next", 32'h5000);
    for (int i = 0; i < 5; i++) wr(32'h6000 + 32'(i));
    repeat (99) tick();
    wr(32'h6005);
    chk("tmo_race_drop", {24'd0, drop_cnt}, 32'd1);
    for (int i = 6; i < 16; i++) wr(32'h6000 + 32'(i));
    drain_pkt("tmo_race", 32'h6000);
`else
    chk("notmo_drop", {24'd0, drop_cnt}, 32'd0);
    for (int i = 5; i < 16; i++) wr(32'h4000 + 32'(i));
    drain_pkt("notmo", 32'h4000);
`endif

    for (int i = 0; i < 24; i++) wr(32'h7000 + 32'(i));
    for (int i = 0; i < 3; i++) begin
      chk("sr_d", exfifo_if_d, 32'h7000 + 32'(i));
      rd();
    end
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    chk("sr_empty", {31'd0, exfifo_if_rdempty}, 32'd1);
    chk("sr_full", {31'd0, h_wrfull}, 32'd0);
    chk("sr_ovf", {31'd0, ovf}, 32'd0);
    chk("sr_drop", {24'd0, drop_cnt}, 32'd0);
    chk("sr_d0", exfifo_if_d, 32'd0);
    for (int i = 0; i < 16; i++) begin
      wr(32'h8000 + 32'(i));
      if (i == 14) chk("sr_pkt_hidden", {31'd0, exfifo_if_rdempty}, 32'd1);
    end
    drain_pkt("sr_pkt", 32'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
